// File: rtl/axi4_lite_master_arbiter.sv
// Two-requester arbiter in front of a single AXI4-Lite master command port (port 0 = LSU, port 1 = fetch).
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 wins every tie.
module axi4_lite_master_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rq0_req,
   input  logic                  rq0_we,
   input  logic [ADDR_WIDTH-1:0] rq0_addr,
   input  logic [DATA_WIDTH-1:0] rq0_wdata,
   input  logic [3:0]            rq0_wstrb,
   output logic                  rq0_done,
   output logic [DATA_WIDTH-1:0] rq0_rdata,
   input  logic                  rq1_req,
   input  logic                  rq1_we,
   input  logic [ADDR_WIDTH-1:0] rq1_addr,
   input  logic [DATA_WIDTH-1:0] rq1_wdata,
   input  logic [3:0]            rq1_wstrb,
   output logic                  rq1_done,
   output logic [DATA_WIDTH-1:0] rq1_rdata,
   output logic                  write_start,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [3:0]            write_strobe,
   input  logic                  write_busy,
   output logic                  read_start,
   output logic [ADDR_WIDTH-1:0] read_addr,
   input  logic [DATA_WIDTH-1:0] read_data,
   input  logic                  read_busy,
   output logic                  grant_id,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } state_t;

   state_t                state_q;
   logic                  we_q;
   logic                  grant_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_grant_q;
`endif
   logic                  write_start_q;
   logic                  read_start_q;
   logic [ADDR_WIDTH-1:0] write_addr_q;
   logic [DATA_WIDTH-1:0] write_data_q;
   logic [3:0]            write_strobe_q;
   logic [ADDR_WIDTH-1:0] read_addr_q;
   logic                  rq0_done_q;
   logic                  rq1_done_q;
   logic [DATA_WIDTH-1:0] rq0_rdata_q;
   logic [DATA_WIDTH-1:0] rq1_rdata_q;

   logic                  win_d;
   logic                  win_we_d;
   logic [ADDR_WIDTH-1:0] win_addr_d;
   logic [DATA_WIDTH-1:0] win_wdata_d;
   logic [3:0]            win_wstrb_d;
   logic                  busy_sel;
   logic [DATA_WIDTH-1:0] cap_d;

   // Handshake: a requester raises req with stable fields and holds it until it sees a one-cycle
   // done; requests are only sampled in IDLE, so a req still high during RESP starts a new grant.
   always_comb begin
      win_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      if (rq0_req && rq1_req) win_d = ~last_grant_q;
      else                    win_d = rq1_req;
`else
      win_d = rq1_req & ~rq0_req;
`endif
      win_we_d    = win_d ? rq1_we    : rq0_we;
      win_addr_d  = win_d ? rq1_addr  : rq0_addr;
      win_wdata_d = win_d ? rq1_wdata : rq0_wdata;
      win_wstrb_d = win_d ? rq1_wstrb : rq0_wstrb;
      busy_sel    = we_q ? write_busy : read_busy;
      cap_d       = we_q ? '0 : read_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         we_q           <= 1'b0;
         grant_q        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q   <= 1'b1;
`endif
         write_start_q  <= 1'b0;
         read_start_q   <= 1'b0;
         write_addr_q   <= '0;
         write_data_q   <= '0;
         write_strobe_q <= '0;
         read_addr_q    <= '0;
         rq0_done_q     <= 1'b0;
         rq1_done_q     <= 1'b0;
         rq0_rdata_q    <= '0;
         rq1_rdata_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rq0_req || rq1_req) begin
                  grant_q <= win_d;
                  we_q    <= win_we_d;
                  if (win_we_d) begin
                     write_addr_q   <= win_addr_d;
                     write_data_q   <= win_wdata_d;
                     write_strobe_q <= win_wstrb_d;
                     write_start_q  <= 1'b1;
                  end else begin
                     read_addr_q  <= win_addr_d;
                     read_start_q <= 1'b1;
                  end
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               write_start_q <= 1'b0;
               read_start_q  <= 1'b0;
               state_q       <= ST_WAIT_BUSY;
            end
            // The master may take several cycles to raise busy after the start pulse.
            ST_WAIT_BUSY: begin
               if (busy_sel) state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (!busy_sel) begin
                  if (grant_q) begin
                     rq1_done_q  <= 1'b1;
                     rq1_rdata_q <= cap_d;
                  end else begin
                     rq0_done_q  <= 1'b1;
                     rq0_rdata_q <= cap_d;
                  end
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               rq0_done_q <= 1'b0;
               rq1_done_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
               last_grant_q <= grant_q;
`endif
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign write_start  = write_start_q;
   assign read_start   = read_start_q;
   assign write_addr   = write_addr_q;
   assign write_data   = write_data_q;
   assign write_strobe = write_strobe_q;
   assign read_addr    = read_addr_q;
   assign rq0_done     = rq0_done_q;
   assign rq1_done     = rq1_done_q;
   assign rq0_rdata    = rq0_rdata_q;
   assign rq1_rdata    = rq1_rdata_q;
   assign grant_id     = grant_q;
   assign dbg_state_o  = state_q;

endmodule
